// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter and select controller for a 4-to-1 mux.
// Registered one-hot grant plus matching select, bursts capped at HOLD_MAX.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   req    per-requester request, req[k] for requester k
//   gnt    registered one-hot grant, zero when idle
//   s1,s0  mux select = index of the owner (holds last value when idle)
//   busy   high while any grant bit is set
module mux4_rr_arbiter #(
    parameter int unsigned HOLD_MAX = 8,
    parameter int unsigned CNT_W    = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic       s1,
    output logic       s0,
    output logic       busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_MAX - 1);

    state_t           state_q, state_d;
    logic [1:0]       owner_q, owner_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       gnt_d;
    logic             busy_d;
    logic [1:0]       base;
    logic [2:0]       win;
    logic             rel;

    // Returns {found, index} of the first set request scanning
    // upward from base, wrapping mod 4.
    function automatic logic [2:0] pick(
        input logic [3:0] r,
        input logic [1:0] b
    );
        logic [2:0] res;
        logic [1:0] idx;
        res = '0;
        for (int k = 3; k >= 0; k--) begin
            idx = b + k[1:0];
            if (r[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            gnt     <= '0;
            s1      <= 1'b0;
            s0      <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            gnt     <= gnt_d;
            s1      <= owner_d[1];
            s0      <= owner_d[0];
            busy    <= busy_d;
        end
    end

    // On release the new pointer (owner+1) is used in the same edge,
    // so the scan base is chosen ahead of the pointer update.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        rel     = !req[owner_q] || (cnt_q == CNT_LAST);
        base    = (state_q == GRANT) ? owner_q + 2'd1 : ptr_q;
        win     = pick(req, base);
        unique case (state_q)
            IDLE: begin
                if (win[2]) begin
                    state_d = GRANT;
                    owner_d = win[1:0];
                    cnt_d   = '0;
                end
            end
            GRANT: begin
                if (!rel) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else begin
                    ptr_d = owner_q + 2'd1;
                    cnt_d = '0;
                    if (win[2]) owner_d = win[1:0];
                    else        state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        gnt_d  = '0;
        busy_d = 1'b0;
        if (state_d == GRANT) begin
            gnt_d  = 4'b0001 << owner_d;
            busy_d = 1'b1;
        end
    end

endmodule
